ar_rr_arbiter: RTL and testbench
================================

# ar_rr_arbiter

Round-robin arbiter sharing one reorder-buffer AR/R slave port among four requesters. It grants one requester per AR transaction and prefixes the requester index onto a 2-bit local ID to form the 4-bit AXI ID. It routes R beats back by the ID prefix and caps outstanding reads per requester. It sits between the requester masters and the reorder buffer's slave AR/R interface.

## Interface

- DATA_WIDTH, 8, R data width
- MAX_OUTSTANDING, 4, max accepted-but-unreturned reads per requester (1..15)
- clk  in  1  clock
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- s_arid_i  in  8  packed local IDs, requester k at bits [2k+1:2k]
- s_arvalid_i  in  4  AR valid per requester
- s_arready_o  out  4  AR ready per requester
- s_rdata_o  out  4*DATA_WIDTH  R data per requester, requester k at slice k
- s_rid_o  out  8  local R ID per requester
- s_rvalid_o  out  4  R valid per requester
- s_rready_i  in  4  R ready per requester
- m_arid_o  out  4  {requester index[1:0], local id[1:0]}
- m_arvalid_o  out  1  AR valid toward reorder buffer
- m_arready_i  in  1  AR ready from reorder buffer
- m_rdata_i  in  DATA_WIDTH  R data from reorder buffer
- m_rid_i  in  4  R ID from reorder buffer
- m_rvalid_i  in  1  R valid from reorder buffer
- m_rready_o  out  1  R ready toward reorder buffer
- err_o  out  1  sticky protocol error flag

## Operation

- State: IDLE (no AR held), BUSY (AR held in output register).
- Eligible(k) = s_arvalid_i[k] && cnt[k] < MAX_OUTSTANDING.
- Grant condition: state IDLE, or state BUSY with m_arready_i high.
- Grant selection: the first eligible k scanning from ptr+1 mod 4 upward.
- On grant:
  - s_arready_o[k]=1 in the same cycle (combinational); all other bits 0.
  - ar_reg <= {k, s_arid_i[2k+1:2k]}; ptr <= k; state <= BUSY.
- BUSY:
  - m_arvalid_o=1 and m_arid_o=ar_reg, both held stable until m_arready_i.
  - On m_arready_i with no new grant: state <= IDLE.
- R routing (combinational): idx=m_rid_i[3:2].
  - s_rvalid_o[idx]=m_rvalid_i; other bits 0.
  - s_rid_o[k]=m_rid_i[1:0] for all k.
  - s_rdata_o slices all equal m_rdata_i.
  - m_rready_o=s_rready_i[idx].
- Counters cnt[k], width 4:
  - +1 on s_arvalid_i[k]&&s_arready_o[k].
  - -1 on R handshake routed to k.
  - Both events in one cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING, never wraps below 0.
- R handshake to k while cnt[k]==0: err_o <= 1 (sticky until reset), cnt[k] stays 0, beat still forwarded.

## Timing

- Reset (rst high at clk edge):
  - state IDLE, ptr=3 (requester 0 has first priority), cnt=0, ar_reg=0, err_o=0.
  - m_arvalid_o=0, m_arid_o=0, s_arready_o=0.
- Reset mid-BUSY drops the held AR without handshake. Counters clear, so in-flight R beats arriving after reset raise err_o.
- AR latency: s_ar handshake in cycle N leads to m_arvalid_o high from cycle N+1.
- Back-to-back throughput: one AR per cycle while m_arready_i stays high.
- m_arid_o is 0 whenever m_arvalid_o=0.
- R path has zero latency; no registers.
- No eligible requester: no grant, ptr unchanged.
- Counter-saturated requester is skipped; it is re-eligible the cycle after its count drops.

## Test plan

- Reset, then all four s_arvalid_i=1 with m_arready_i=1 -> grants 0,1,2,3,0 on consecutive cycles; m_arid_o prefixes 0,1,2,3,0 starting one cycle after each grant.
- Only requester 2 valid, local id 3, m_arready_i=0 for 3 cycles -> m_arid_o=4'hB held stable 3 cycles; s_arready_o=0 to all during the hold; IDLE after handshake.
- Requester 1 issues 4 ARs with no R returned -> 5th AR is stalled and requesters 0/2/3 still get grants. One R with m_rid_i=4'h5 -> s_rvalid_o=4'b0010, s_rid_o[3:2]=2'b01; requester 1 grantable next cycle.
- m_rid_i=4'hE, m_rvalid_i=1, s_rready_i=4'b0111 -> m_rready_o=0; s_rready_i[3]=1 -> m_rready_o=1 and cnt[3] decrements.
- Same cycle: requester 0 AR accept and R beat to requester 0 -> cnt[0] unchanged.
- R beat to requester 2 with cnt[2]=0 -> err_o=1 next cycle and stays high until rst.

Source files
------------

// File: rtl/ar_rr_arbiter.sv
// ar_rr_arbiter
//
// Round-robin arbiter that shares one reorder-buffer AR/R slave port among
// four requesters. A granted AR is captured in an output register and
// presented with the 4-bit ID {requester index, local id}. R beats are routed
// back combinationally by the ID prefix. A per-requester counter caps the
// number of accepted-but-unreturned reads.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   s_arid_i        packed 2-bit local IDs, requester k at [2k+1:2k]
//   s_arvalid_i     AR valid per requester
//   s_arready_o     AR ready per requester (one-hot or zero)
//   s_rdata_o       R data per requester (all slices carry m_rdata_i)
//   s_rid_o         local R ID per requester (all carry m_rid_i[1:0])
//   s_rvalid_o      R valid per requester (routed by m_rid_i[3:2])
//   s_rready_i      R ready per requester
//   m_arid_o        {requester index, local id}; zero while m_arvalid_o is low
//   m_arvalid_o     AR valid toward the reorder buffer
//   m_arready_i     AR ready from the reorder buffer
//   m_rdata_i       R data from the reorder buffer
//   m_rid_i         R ID from the reorder buffer
//   m_rvalid_i      R valid from the reorder buffer
//   m_rready_o      R ready toward the reorder buffer
//   err_o           sticky flag: R beat returned to a requester with nothing outstanding

module ar_rr_arbiter #(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              s_arid_i,
  input  logic [3:0]              s_arvalid_i,
  output logic [3:0]              s_arready_o,
  output logic [4*DATA_WIDTH-1:0] s_rdata_o,
  output logic [7:0]              s_rid_o,
  output logic [3:0]              s_rvalid_o,
  input  logic [3:0]              s_rready_i,
  output logic [3:0]              m_arid_o,
  output logic                    m_arvalid_o,
  input  logic                    m_arready_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [3:0]              m_rid_i,
  input  logic                    m_rvalid_i,
  output logic                    m_rready_o,
  output logic                    err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  state_t     state, state_next;
  logic [1:0] ptr;
  logic [3:0] ar_reg;
  logic [3:0] cnt [4];

  logic [3:0] eligible;
  logic       grant_ok;
  logic       grant;
  logic [1:0] grant_idx;
  logic [1:0] r_idx;
  logic       r_hs;
  logic [3:0] cnt_inc;
  logic [3:0] cnt_dec;

  // A new AR may be captured when the output register is empty or is being
  // drained this cycle.
  assign grant_ok = (state == IDLE) || m_arready_i;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      eligible[k] = s_arvalid_i[k] && (cnt[k] < MAX_CNT);
    end
  end

  // Scan ptr+1, ptr+2, ptr+3, ptr (2-bit wrap) and take the first eligible.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    grant     = 1'b0;
    grant_idx = ptr;
    for (int i = 1; i <= 4; i++) begin
      if (!grant && eligible[ptr + 2'(i)]) begin
        grant     = 1'b1;
        grant_idx = ptr + 2'(i);
      end
    end
    grant = grant && grant_ok;
  end

  assign s_arready_o = grant ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    state_next = state;
    if (grant) begin
      state_next = BUSY;
    end else if (state == BUSY && m_arready_i) begin
      state_next = IDLE;
    end
  end

  assign m_arvalid_o = (state == BUSY);
  assign m_arid_o    = (state == BUSY) ? ar_reg : 4'h0;

  // R path: purely combinational, steered by the requester prefix of the ID.
  assign r_idx      = m_rid_i[3:2];
  assign s_rvalid_o = m_rvalid_i ? (4'b0001 << r_idx) : 4'b0000;
  assign s_rid_o    = {4{m_rid_i[1:0]}};
  assign s_rdata_o  = {4{m_rdata_i}};
  assign m_rready_o = s_rready_i[r_idx];
  assign r_hs       = m_rvalid_i && m_rready_o;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_inc[k] = s_arvalid_i[k] && s_arready_o[k];
      cnt_dec[k] = r_hs && (r_idx == 2'(k));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 2'd3;
      ar_reg <= 4'h0;
      err_o  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cnt[k] <= 4'd0;
      end
    end else begin
      state <= state_next;
      if (grant) begin
        ar_reg <= {grant_idx, s_arid_i[{grant_idx, 1'b0} +: 2]};
        ptr    <= grant_idx;
      end
      // A beat returned to an idle requester is still forwarded, but flagged.
      if (r_hs && cnt[r_idx] == 4'd0) begin
        err_o <= 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        if (cnt_inc[k] && !cnt_dec[k]) begin
          cnt[k] <= cnt[k] + 4'd1;
        end else if (cnt_dec[k] && !cnt_inc[k] && cnt[k] != 4'd0) begin
          cnt[k] <= cnt[k] - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ar_rr_arbiter.sv
// Testbench for ar_rr_arbiter: a vector table for the round-robin AR
// sequence plus directed sequences for hold, saturation, R routing, counter
// balance and the sticky error flag.

module tb_ar_rr_arbiter;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      s_arid_i;
  logic [3:0]      s_arvalid_i;
  logic [3:0]      s_arready_o;
  logic [4*DW-1:0] s_rdata_o;
  logic [7:0]      s_rid_o;
  logic [3:0]      s_rvalid_o;
  logic [3:0]      s_rready_i;
  logic [3:0]      m_arid_o;
  logic            m_arvalid_o;
  logic            m_arready_i;
  logic [DW-1:0]   m_rdata_i;
  logic [3:0]      m_rid_i;
  logic            m_rvalid_i;
  logic            m_rready_o;
  logic            err_o;

  int total = 0;
  int bad   = 0;

  ar_rr_arbiter #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_arid_i    (s_arid_i),
    .s_arvalid_i (s_arvalid_i),
    .s_arready_o (s_arready_o),
    .s_rdata_o   (s_rdata_o),
    .s_rid_o     (s_rid_o),
    .s_rvalid_o  (s_rvalid_o),
    .s_rready_i  (s_rready_i),
    .m_arid_o    (m_arid_o),
    .m_arvalid_o (m_arvalid_o),
    .m_arready_i (m_arready_i),
    .m_rdata_i   (m_rdata_i),
    .m_rid_i     (m_rid_i),
    .m_rvalid_i  (m_rvalid_i),
    .m_rready_o  (m_rready_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] arvalid;
    logic [7:0] arid;
    logic       arready;
    logic [3:0] exp_arready;
    logic       exp_mvalid;
    logic [3:0] exp_mid;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled here, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_arid_i    = 8'h00;
    s_arvalid_i = 4'h0;
    s_rready_i  = 4'h0;
    m_arready_i = 1'b0;
    m_rdata_i   = '0;
    m_rid_i     = 4'h0;
    m_rvalid_i  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic r_beat(input logic [3:0] rid, input logic [3:0] rready);
    m_rid_i    = rid;
    m_rvalid_i = 1'b1;
    s_rready_i = rready;
  endtask

  task automatic r_idle();
    m_rvalid_i = 1'b0;
    s_rready_i = 4'h0;
  endtask

  initial begin
    // Local ids: req0=3, req1=2, req2=1, req3=0.
    vecs[0] = '{4'hF, 8'h1B, 1'b1, 4'b0001, 1'b0, 4'h0};
    vecs[1] = '{4'hF, 8'h1B, 1'b1, 4'b0010, 1'b1, 4'h3};
    vecs[2] = '{4'hF, 8'h1B, 1'b1, 4'b0100, 1'b1, 4'h6};
    vecs[3] = '{4'hF, 8'h1B, 1'b1, 4'b1000, 1'b1, 4'h9};
    vecs[4] = '{4'hF, 8'h1B, 1'b1, 4'b0001, 1'b1, 4'hC};
    vecs[5] = '{4'h0, 8'h1B, 1'b1, 4'b0000, 1'b1, 4'h3};
    vecs[6] = '{4'h0, 8'h1B, 1'b1, 4'b0000, 1'b0, 4'h0};

    // ---- reset state
    do_reset();
    #1;
    check("rst_mvalid", 32'(m_arvalid_o), 32'h0);
    check("rst_mid",    32'(m_arid_o),    32'h0);
    check("rst_arready",32'(s_arready_o), 32'h0);
    check("rst_err",    32'(err_o),       32'h0);

    // ---- round robin, back to back
    for (int i = 0; i < 7; i++) begin
      s_arvalid_i = vecs[i].arvalid;
      s_arid_i    = vecs[i].arid;
      m_arready_i = vecs[i].arready;
      #1;
      check($sformatf("rr%0d_arready", i), 32'(s_arready_o), 32'(vecs[i].exp_arready));
      check($sformatf("rr%0d_mvalid",  i), 32'(m_arvalid_o), 32'(vecs[i].exp_mvalid));
      check($sformatf("rr%0d_mid",     i), 32'(m_arid_o),    32'(vecs[i].exp_mid));
      step();
    end

    // ---- hold: requester 2, local id 3, slave not ready for 3 cycles
    do_reset();
    s_arvalid_i = 4'b0100;
    s_arid_i    = 8'h30;
    m_arready_i = 1'b0;
    #1;
    check("hold_grant", 32'(s_arready_o), 32'h4);
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold%0d_mvalid", i),  32'(m_arvalid_o), 32'h1);
      check($sformatf("hold%0d_mid", i),     32'(m_arid_o),    32'hB);
      check($sformatf("hold%0d_arready", i), 32'(s_arready_o), 32'h0);
      step();
    end
    s_arvalid_i = 4'h0;
    m_arready_i = 1'b1;
    #1;
    check("hold_hs_mid", 32'(m_arid_o), 32'hB);
    step();
    check("hold_idle_mvalid", 32'(m_arvalid_o), 32'h0);
    check("hold_idle_mid",    32'(m_arid_o),    32'h0);

    // ---- saturation of requester 1 (local id 1)
    do_reset();
    s_arvalid_i = 4'b0010;
    s_arid_i    = 8'h04;
    m_arready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("sat_grant%0d", i), 32'(s_arready_o), 32'h2);
      step();
    end
    #1;
    check("sat_stall", 32'(s_arready_o), 32'h0);
    step();
    s_arvalid_i = 4'hF;
    #1;
    check("sat_skip_a", 32'(s_arready_o), 32'h4);
    step();
    check("sat_skip_b", 32'(s_arready_o), 32'h8);
    step();
    check("sat_skip_c", 32'(s_arready_o), 32'h1);
    step();
    check("sat_skip_d", 32'(s_arready_o), 32'h4);
    step();
    // R beat back to requester 1 frees one slot
    s_arvalid_i = 4'h0;
    m_rdata_i   = 8'hA5;
    r_beat(4'h5, 4'b0010);
    #1;
    check("r5_rvalid", 32'(s_rvalid_o),   32'h2);
    check("r5_rid",    32'(s_rid_o[3:2]), 32'h1);
    check("r5_rready", 32'(m_rready_o),   32'h1);
    check("r5_rdata",  32'(s_rdata_o),    32'hA5A5A5A5);
    step();
    r_idle();
    s_arvalid_i = 4'b0010;
    #1;
    check("sat_regrant", 32'(s_arready_o), 32'h2);
    step();

    // ---- R ready steering to requester 3 (cnt[3]=1 here)
    s_arvalid_i = 4'h0;
    r_beat(4'hE, 4'b0111);
    #1;
    check("rE_rready_lo", 32'(m_rready_o),   32'h0);
    check("rE_rvalid",    32'(s_rvalid_o),   32'h8);
    check("rE_rid",       32'(s_rid_o[7:6]), 32'h2);
    step();
    s_rready_i = 4'b1000;
    #1;
    check("rE_rready_hi", 32'(m_rready_o), 32'h1);
    step();
    r_idle();
    #1;
    check("rE_no_err", 32'(err_o), 32'h0);
    // cnt[3] must now be 0: one more beat to 3 is an error
    r_beat(4'hC, 4'b1000);
    step();
    r_idle();
    #1;
    check("rE_dec_seen", 32'(err_o), 32'h1);

    // ---- simultaneous accept and return for requester 0
    do_reset();
    s_arvalid_i = 4'b0001;
    s_arid_i    = 8'h00;
    m_arready_i = 1'b1;
    step();                       // cnt[0] = 1
    r_beat(4'h0, 4'b0001);
    #1;
    check("same_grant", 32'(s_arready_o), 32'h1);
    step();                       // both events: cnt[0] stays 1
    s_arvalid_i = 4'h0;
    #1;
    check("same_no_err", 32'(err_o), 32'h0);
    step();                       // cnt[0] 1 -> 0, legal
    #1;
    check("same_dec_ok", 32'(err_o), 32'h0);
    step();                       // cnt[0] already 0: error
    r_idle();
    #1;
    check("same_err", 32'(err_o), 32'h1);

    // ---- error on requester 2 with nothing outstanding
    do_reset();
    r_beat(4'h8, 4'b0100);
    #1;
    check("err_fwd_rvalid", 32'(s_rvalid_o), 32'h4);
    check("err_pre",        32'(err_o),      32'h0);
    step();
    r_idle();
    check("err_set", 32'(err_o), 32'h1);
    step();
    step();
    check("err_sticky", 32'(err_o), 32'h1);
    do_reset();
    #1;
    check("err_cleared", 32'(err_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
